// File: rtl/rng_health_buffer.sv
// rtl/rng_health_buffer.sv - online health tests (zero, repetition, stuck-bit) on LFSR words
// with a small FIFO toward the consumer; sticky alarm flushes and blocks output.
module rng_health_buffer #(
  parameter int DEPTH        = 8,
  parameter int WARMUP       = 4,
  parameter int RCT_CUTOFF   = 4,
  parameter int STUCK_WINDOW = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                in_word,
  input  logic                       in_valid,
  input  logic                       clear_alarm,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       alarm,
  output logic [2:0]                 fail_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int SW = $clog2(STUCK_WINDOW + 1);
  localparam int WW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {STARTUP, RUN, ALARM} state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     prev;
  logic            prev_ok;
  logic [RW-1:0]   rct_cnt;
  logic [31:0]     acc;
  logic [SW-1:0]   win_cnt;
  logic [WW-1:0]   warm_cnt;

  logic            sample, zero_fail, rct_fail, stuck_fail, win_end, any_fail;
  logic            pop, push;
  logic [RW-1:0]   rct_next;
  logic [31:0]     acc_next;
  logic [SW-1:0]   win_next;
  logic [AW-1:0]   rd_nx, wr_nx;
  logic [LW-1:0]   lvl_nx;
  logic [31:0]     head_nx;

  always_comb begin
    sample     = in_valid && (state != ALARM);
    zero_fail  = (in_word == 32'd0);
    rct_next   = (prev_ok && in_word == prev) ? rct_cnt + RW'(1) : RW'(1);
    rct_fail   = (rct_next >= RW'(RCT_CUTOFF));
    acc_next   = acc | (in_word ^ prev);
    win_next   = win_cnt + SW'(1);
    win_end    = prev_ok && (win_next == SW'(STUCK_WINDOW));
    stuck_fail = win_end && (acc_next != 32'hFFFF_FFFF);
    any_fail   = sample && (zero_fail || rct_fail || stuck_fail);
    pop        = out_valid && out_ready;
    push       = sample && (state == RUN) && !any_fail && ((level != LW'(DEPTH)) || pop);

    rd_nx  = rd_ptr + AW'(pop);
    wr_nx  = wr_ptr + AW'(push);
    lvl_nx = level + LW'(push) - LW'(pop);
    if (any_fail) begin
      rd_nx  = '0;
      wr_nx  = '0;
      lvl_nx = '0;
    end
    // The word being written this cycle becomes the head when it lands on the next read slot.
    head_nx = (push && wr_ptr == rd_nx) ? in_word : mem[rd_nx];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STARTUP;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      alarm     <= 1'b0;
      fail_code <= '0;
      prev      <= '0;
      prev_ok   <= 1'b0;
      rct_cnt   <= '0;
      acc       <= '0;
      win_cnt   <= '0;
      warm_cnt  <= '0;
    end else begin
      rd_ptr    <= rd_nx;
      wr_ptr    <= wr_nx;
      level     <= lvl_nx;
      out_valid <= (lvl_nx != '0);
      if (lvl_nx != '0) out_data <= head_nx;

      case (state)
        STARTUP, RUN: begin
          if (sample) begin
            prev    <= in_word;
            prev_ok <= 1'b1;
            rct_cnt <= rct_next;
            if (prev_ok) begin
              acc     <= win_end ? 32'd0 : acc_next;
              win_cnt <= win_end ? '0 : win_next;
            end
            if (any_fail) begin
              state     <= ALARM;
              alarm     <= 1'b1;
              fail_code <= {stuck_fail, rct_fail, zero_fail};
            end else if (state == STARTUP) begin
              warm_cnt <= warm_cnt + WW'(1);
              if (warm_cnt + WW'(1) == WW'(WARMUP)) state <= RUN;
            end
          end
        end
        default: begin
          if (clear_alarm) begin
            state     <= STARTUP;
            alarm     <= 1'b0;
            fail_code <= '0;
            prev      <= '0;
            prev_ok   <= 1'b0;
            rct_cnt   <= '0;
            acc       <= '0;
            win_cnt   <= '0;
            warm_cnt  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_health_buffer.sv
// tb/tb_rng_health_buffer.sv - randomized scoreboard bench for rng_health_buffer
// against a rule-level model of the health tests and FIFO.
module tb_rng_health_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        clear_alarm = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  level;
  logic        alarm;
  logic [2:0]  fail_code;

  rng_health_buffer dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .clear_alarm(clear_alarm), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .alarm(alarm), .fail_code(fail_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase, warmup count, word history for tests, FIFO contents.
  logic [31:0] sbq[$];
  int          m_phase;        // 0 startup, 1 run, 2 alarm
  int          m_warm;
  logic [31:0] m_hist[$];      // words since window start (first one is the reference)
  int          m_run_len;      // length of the current identical-word run
  int          m_count;
  logic        m_alarm;
  logic [2:0]  m_fc;

  task automatic model_clear_tests();
    m_hist.delete();
    m_run_len = 0;
    m_warm    = 0;
  endtask

  task automatic model_reset();
    model_clear_tests();
    m_phase = 0; m_count = 0; m_alarm = 0; m_fc = 0;
    sbq.delete();
  endtask

  task automatic model_update(input logic v, input logic [31:0] w, input logic rdy, input logic clr);
    bit pop, z, r, s, push;
    logic [31:0] orx;
    pop = (m_count > 0) && rdy;
    if (m_phase == 2) begin
      if (clr) begin
        model_clear_tests();
        m_phase = 0; m_alarm = 0; m_fc = 0;
      end
      return;
    end
    push = 0;
    if (v) begin
      z = (w == 0);
      if (m_hist.size() > 0 && m_hist[$] == w) m_run_len++;
      else m_run_len = 1;
      r = (m_run_len >= 4);
      s = 0;
      m_hist.push_back(w);
      // A window closes after 64 comparisons, i.e. 65 words including its reference word.
      if (m_hist.size() == 65) begin
        orx = 0;
        for (int i = 1; i < 65; i++) orx |= m_hist[i] ^ m_hist[i-1];
        s = (orx != 32'hFFFF_FFFF);
        m_hist.delete();
        m_hist.push_back(w);
      end
      if (z || r || s) begin
        m_phase = 2; m_alarm = 1; m_fc = {s, r, z};
        m_count = 0;
        sbq.delete();
        return;
      end
      if (m_phase == 1) begin
        if (m_count < 8 || pop) begin
          push = 1;
          sbq.push_back(w);
        end
      end else begin
        m_warm++;
        if (m_warm == 4) m_phase = 1;
      end
    end
    m_count = m_count + int'(push) - int'(pop);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(m_count));
    chk({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
    chk({tag, ".fail_code"}, 32'(fail_code), 32'(m_fc));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_count != 0));
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic clr,
                      input string tag);
    in_valid = v; in_word = w; out_ready = rdy; clear_alarm = clr;
    @(negedge clk); #1;
    model_update(v, w, rdy, clr);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; clear_alarm = 0;
    @(negedge clk); #1;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    check_outputs("reset");
    chk("reset.out_data", out_data, 32'd0);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom();
    if (w == 0) w = 32'h1;
    return w;
  endfunction

  // Monitor: pops the scoreboard on every DUT handshake and checks stall stability.
  logic        stall_prev = 0;
  logic [31:0] stall_data = 0;
  always @(negedge clk) begin
    if (!rst && stall_prev && out_valid) chk("stall_stable", out_data, stall_data);
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_output", out_data, 32'hxxxx_xxxx);
      else chk("out_data", out_data, sbq.pop_front());
    end
    stall_prev = !rst && out_valid && !out_ready;
    stall_data = out_data;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last;
    @(posedge clk); #1;
    do_reset();

    // Warmup: words 1..4 discarded, 5.. stream through with level <= 1.
    for (int i = 1; i <= 10; i++) step(1, 32'(i), 1, 0, "warmup");

    // Zero lock-up, then in_valid ignored while in alarm.
    step(1, 32'h0, 1, 0, "zero");
    for (int i = 0; i < 5; i++) step(1, rnd_word(), 1, 0, "alarm_hold");
    step(0, 0, 1, 1, "clear1");

    // Warmup again, then repetition failure on the fourth copy.
    for (int i = 0; i < 4; i++) step(1, rnd_word(), 0, 0, "warm2");
    for (int i = 0; i < 4; i++) step(1, 32'hDEADBEEF, 0, 0, "rct");
    step(0, 0, 1, 1, "clear2");
    for (int i = 0; i < 6; i++) step(1, rnd_word(), 1, 0, "after_rct");

    // Stuck bit 7: 65 words from clear give 64 comparisons.
    step(1, 32'h0, 1, 0, "zero2");
    step(0, 0, 1, 1, "clear3");
    for (int i = 0; i < 66; i++) step(1, rnd_word() | 32'h80, 1, 0, "stuck");

    // Control: full toggling across several windows.
    step(0, 0, 1, 1, "clear4");
    for (int i = 0; i < 200; i++) step(1, rnd_word(), 1'($urandom_range(0, 1)), 0, "control");

    // Backpressure: 12 words into an 8-deep FIFO, then push+pop at full, then drain.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, rnd_word(), 0, 0, "bp_warm");
    for (int i = 0; i < 12; i++) step(1, rnd_word(), 0, 0, "bp_fill");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "bp_stall");
    step(1, rnd_word(), 1, 0, "bp_full_pushpop");
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, "bp_drain");

    // Reset while in alarm, and while holding 5 words.
    step(1, 32'h0, 0, 0, "zero3");
    do_reset();
    for (int i = 0; i < 9; i++) step(1, rnd_word(), 0, 0, "lvl5");
    do_reset();
    for (int i = 0; i < 5; i++) step(1, rnd_word(), 0, 0, "rewarm");

    // Random mix with injected zeros, repeats and clear pulses.
    last = 32'h1;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      int sel;
      sel = $urandom_range(0, 59);
      if (sel == 0) w = 32'h0;
      else if (sel < 12) w = last;
      else w = rnd_word();
      last = w;
      step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) == 0), "random");
    end

    for (int i = 0; i < 12; i++) step(0, 0, 1, 1, "final_drain");
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
